// File: rtl/cdi_pointing_pkg.sv
// rtl/cdi_pointing_pkg.sv - shared types, ID bytes and arithmetic helpers for the CD-i pointing generator
package cdi_pointing_pkg;

    typedef enum logic [2:0] {
        ST_DEVICE_ID,
        ST_IDLE,
        ST_BYTE0,
        ST_BYTE1,
        ST_BYTE2
    } e_state;

    typedef enum logic {
        DEV_MANEUVERING = 1'b0,
        DEV_RELATIVE    = 1'b1
    } e_device_type;

    typedef enum logic [1:0] {
        MF_AUTO        = 2'd0,
        MF_MANEUVERING = 2'd1,
        MF_RELATIVE    = 2'd2,
        MF_AUTO_ALT    = 2'd3
    } e_mode_force;

    // 'J' | 0x80 and 'M' | 0x80
    localparam logic [7:0] ID_MANEUVERING = 8'hCA;
    localparam logic [7:0] ID_RELATIVE    = 8'hCD;

    // Remove the deadzone band, then scale down; integer division truncates toward zero.
    function automatic logic signed [7:0] deadzone_calc(input logic signed [7:0] v, input int dz, input int div);
        int t;
        int q;
        t = int'(v);
        if (t > dz)
            t = t - dz;
        else if (t < -dz)
            t = t + dz;
        else
            t = 0;
        q = t / div;
        return q[7:0];
    endfunction

    // Clamp a wide accumulator into the +/-sat range carried by one frame.
    function automatic logic signed [7:0] mouse_saturate(input logic signed [15:0] acc, input int sat);
        int a;
        a = int'(acc);
        if (a > sat)
            a = sat;
        else if (a < -sat)
            a = -sat;
        return a[7:0];
    endfunction

    // Three-byte movement frame: sync/buttons/high bits, then low six bits of X and Y.
    function automatic logic [23:0] pack_frame(input logic b1, input logic b2,
                                               input logic signed [7:0] x, input logic signed [7:0] y);
        return {2'b11, b1, b2, y[7:6], x[7:6], 2'b10, x[5:0], 2'b10, y[5:0]};
    endfunction

endpackage

// File: rtl/pointing_mouse_accumulator.sv
// rtl/pointing_mouse_accumulator.sv - mouse event detect, accumulation with clear-carry and claim latch
module pointing_mouse_accumulator
    import cdi_pointing_pkg::*;
#(
    parameter int MOUSE_THRESH = 2,
    parameter int SAT          = 127
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              toggle,
    input  logic [8:0]        dx_raw,
    input  logic [8:0]        dy_raw,
    input  logic              enable,
    input  logic              acc_clear,
    input  logic              sig_clear,
    output logic signed [7:0] x_sat,
    output logic signed [7:0] y_sat,
    output logic              significant
);

    logic               toggle_q;
    logic               event_seen;
    logic               big_move;
    logic signed [15:0] inc_x;
    logic signed [15:0] inc_y;
    logic signed [15:0] acc_x;
    logic signed [15:0] acc_y;

    // Screen Y grows downward, so the mouse Y increment is negated.
    assign inc_x      = {{7{dx_raw[8]}}, dx_raw};
    assign inc_y      = -{{7{dy_raw[8]}}, dy_raw};
    assign event_seen = toggle ^ toggle_q;
    assign x_sat      = mouse_saturate(acc_x, SAT);
    assign y_sat      = mouse_saturate(acc_y, SAT);

    // A movement is significant when either increment magnitude exceeds the threshold.
    always_comb begin
        big_move = (int'(inc_x) > MOUSE_THRESH) || (int'(inc_x) < -MOUSE_THRESH) ||
                   (int'(inc_y) > MOUSE_THRESH) || (int'(inc_y) < -MOUSE_THRESH);
    end

    // Accumulate on each toggle; a frame latch restarts from the same-cycle increment so no event is lost.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            toggle_q    <= 1'b0;
            acc_x       <= '0;
            acc_y       <= '0;
            significant <= 1'b0;
        end else begin
            toggle_q <= toggle;
            if (acc_clear) begin
                acc_x <= (event_seen && enable) ? inc_x : 16'sd0;
                acc_y <= (event_seen && enable) ? inc_y : 16'sd0;
            end else if (event_seen && enable) begin
                acc_x <= acc_x + inc_x;
                acc_y <= acc_y + inc_y;
            end
            if (event_seen && big_move)
                significant <= 1'b1;
            else if (sig_clear)
                significant <= 1'b0;
        end
    end

endmodule

// File: rtl/pointing_device_gen.sv
// rtl/pointing_device_gen.sv - joystick/mouse to CD-i serial pointing protocol byte generator
module pointing_device_gen
    import cdi_pointing_pkg::*;
#(
    parameter int CLK_HZ       = 30000000,
    parameter int BAUD         = 1200,
    parameter int TICKS_OC     = 200000,
    parameter int DEADZONE     = 14,
    parameter int ANALOG_DIV   = 6,
    parameter int SLOW_SPEED   = 2,
    parameter int FAST_SPEED   = 8,
    parameter int ACCEL_FRAMES = 5,
    parameter int MOUSE_THRESH = 2,
    parameter int SAT          = 127
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [15:0] mister_joystick,
    input  logic [15:0] mister_joystick_analog,
    input  logic [24:0] mister_mouse,
    input  logic        rts,
    input  logic        overclock,
    input  logic [1:0]  mode_force,
    input  logic        serial_ready,
    output logic [7:0]  serial_out_data,
    output logic        serial_out_write,
    output logic        device_type,
    output logic [15:0] frame_count
);

    localparam int TICKS_NORMAL = CLK_HZ * 10 / BAUD;
    localparam int TICKS_MAX    = (TICKS_NORMAL > TICKS_OC) ? TICKS_NORMAL : TICKS_OC;
    localparam int CNT_W        = $clog2(TICKS_MAX);
    localparam logic [CNT_W-1:0] RELOAD_NORMAL = CNT_W'(TICKS_NORMAL - 1);
    localparam logic [CNT_W-1:0] RELOAD_OC     = CNT_W'(TICKS_OC - 1);

    e_state             state_q, state_d;
    e_device_type       dev_q, dev_d, target;
    logic [CNT_W-1:0]   cnt_q, cnt_d, reload;
    logic [7:0]         data_q, data_d, tx_byte;
    logic               write_q, write_d;
    logic signed [7:0]  x_q, x_d, y_q, y_d;
    logic [1:0]         b_q, b_d;
    logic [23:0]        frame_q, frame_d;
    logic [2:0]         accel_q, accel_d;
    logic [15:0]        frame_cnt_q, frame_cnt_d;
    e_state             tx_next;

    logic signed [7:0]  speed, dig_x, dig_y, ana_x, ana_y, x_cur, y_cur;
    logic signed [7:0]  mouse_x, mouse_y;
    logic               b1, b2, joy_move, dpad_idle, tx_needed, mouse_sig;
    logic               acc_clear, sig_clear;
    logic               inputs_unused;

    assign inputs_unused = ^{mister_joystick[15:6], mister_mouse[3:2]};

    pointing_mouse_accumulator #(
        .MOUSE_THRESH (MOUSE_THRESH),
        .SAT          (SAT)
    ) u_mouse (
        .clk         (clk),
        .rst_n       (reset_n),
        .toggle      (mister_mouse[24]),
        .dx_raw      ({mister_mouse[4], mister_mouse[15:8]}),
        .dy_raw      ({mister_mouse[5], mister_mouse[23:16]}),
        .enable      (dev_q == DEV_RELATIVE),
        .acc_clear   (acc_clear),
        .sig_clear   (sig_clear),
        .x_sat       (mouse_x),
        .y_sat       (mouse_y),
        .significant (mouse_sig)
    );

    // Motion sources, target device selection and the "anything to send" test.
    always_comb begin
        speed     = (int'(accel_q) >= ACCEL_FRAMES) ? 8'(FAST_SPEED) : 8'(SLOW_SPEED);
        dig_x     = '0;
        dig_y     = '0;
        if (mister_joystick[0]) dig_x = speed;
        if (mister_joystick[1]) dig_x = -speed;
        if (mister_joystick[2]) dig_y = speed;
        if (mister_joystick[3]) dig_y = -speed;
        ana_x     = deadzone_calc(mister_joystick_analog[7:0], DEADZONE, ANALOG_DIV);
        ana_y     = deadzone_calc(mister_joystick_analog[15:8], DEADZONE, ANALOG_DIV);
        dpad_idle = (mister_joystick[3:0] == 4'd0);
        joy_move  = !dpad_idle || (ana_x != '0) || (ana_y != '0);
        b1        = mister_joystick[5] | mister_mouse[0];
        b2        = mister_joystick[4] | mister_mouse[1];
        if (dev_q == DEV_RELATIVE) begin
            x_cur = mouse_x;
            y_cur = mouse_y;
        end else begin
            x_cur = (ana_x != '0) ? ana_x : dig_x;
            y_cur = (ana_y != '0) ? ana_y : dig_y;
        end
        case (e_mode_force'(mode_force))
            MF_MANEUVERING: target = DEV_MANEUVERING;
            MF_RELATIVE:    target = DEV_RELATIVE;
            default: begin
                if (joy_move)
                    target = DEV_MANEUVERING;
                else if (mouse_sig)
                    target = DEV_RELATIVE;
                else
                    target = dev_q;
            end
        endcase
        tx_needed = ({b1, b2} != b_q) || (x_cur != x_q) || (y_cur != y_q) ||
                    (x_cur != '0) || (y_cur != '0);
    end

    // Byte slot sequencer: countdown, frame decision one tick before the slot ends, stall on !ready.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        data_d      = data_q;
        write_d     = 1'b0;
        dev_d       = dev_q;
        x_d         = x_q;
        y_d         = y_q;
        b_d         = b_q;
        frame_d     = frame_q;
        accel_d     = accel_q;
        frame_cnt_d = frame_cnt_q;
        acc_clear   = 1'b0;
        sig_clear   = 1'b0;
        reload      = overclock ? RELOAD_OC : RELOAD_NORMAL;
        tx_byte     = 8'h00;
        tx_next     = ST_IDLE;
        case (state_q)
            ST_DEVICE_ID: tx_byte = (dev_q == DEV_RELATIVE) ? ID_RELATIVE : ID_MANEUVERING;
            ST_BYTE0: begin tx_byte = frame_q[23:16]; tx_next = ST_BYTE1; end
            ST_BYTE1: begin tx_byte = frame_q[15:8];  tx_next = ST_BYTE2; end
            ST_BYTE2: tx_byte = frame_q[7:0];
            default: ;
        endcase
        if (rts) begin
            state_d = ST_DEVICE_ID;
            cnt_d   = reload;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
            if (state_q == ST_IDLE && cnt_q == CNT_W'(1)) begin
                sig_clear = 1'b1;
                accel_d   = dpad_idle ? 3'd0 : ((accel_q == 3'd7) ? 3'd7 : accel_q + 3'd1);
                if (target != dev_q) begin
                    dev_d   = target;
                    state_d = ST_DEVICE_ID;
                end else if (tx_needed) begin
                    x_d       = x_cur;
                    y_d       = y_cur;
                    b_d       = {b1, b2};
                    frame_d   = pack_frame(b1, b2, x_cur, y_cur);
                    acc_clear = 1'b1;
                    state_d   = ST_BYTE0;
                end
            end
        end else if (state_q == ST_IDLE) begin
            cnt_d = reload;
        end else if (serial_ready) begin
            write_d = 1'b1;
            data_d  = tx_byte;
            cnt_d   = reload;
            state_d = tx_next;
            if (state_q == ST_BYTE2)
                frame_cnt_d = frame_cnt_q + 16'd1;
        end
    end

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_DEVICE_ID;
            cnt_q       <= RELOAD_NORMAL;
            data_q      <= 8'h00;
            write_q     <= 1'b0;
            dev_q       <= DEV_MANEUVERING;
            x_q         <= '0;
            y_q         <= '0;
            b_q         <= '0;
            frame_q     <= '0;
            accel_q     <= '0;
            frame_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            data_q      <= data_d;
            write_q     <= write_d;
            dev_q       <= dev_d;
            x_q         <= x_d;
            y_q         <= y_d;
            b_q         <= b_d;
            frame_q     <= frame_d;
            accel_q     <= accel_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    assign serial_out_data  = data_q;
    assign serial_out_write = write_q;
    assign device_type      = dev_q;
    assign frame_count      = frame_cnt_q;

endmodule

// File: tb/tb_pointing_device_gen.sv
// tb/tb_pointing_device_gen.sv - scoreboard bench for pointing_device_gen
module tb_pointing_device_gen;

    localparam int TICKS = 16;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [15:0] mister_joystick = '0;
    logic [15:0] mister_joystick_analog = '0;
    logic [24:0] mister_mouse = '0;
    logic        rts = 1'b0;
    logic        overclock = 1'b0;
    logic [1:0]  mode_force = 2'd0;
    logic        serial_ready = 1'b1;
    logic [7:0]  serial_out_data;
    logic        serial_out_write;
    logic        device_type;
    logic [15:0] frame_count;

    int asserts = 0;
    int fails = 0;
    int write_cnt = 0;
    int exp_frames = 0;
    logic [7:0] exp_q[$];

    always #5 clk = ~clk;

    pointing_device_gen #(
        .CLK_HZ   (1600),
        .BAUD     (1000),
        .TICKS_OC (8)
    ) dut (
        .clk                    (clk),
        .reset_n                (reset_n),
        .mister_joystick        (mister_joystick),
        .mister_joystick_analog (mister_joystick_analog),
        .mister_mouse           (mister_mouse),
        .rts                    (rts),
        .overclock              (overclock),
        .mode_force             (mode_force),
        .serial_ready           (serial_ready),
        .serial_out_data        (serial_out_data),
        .serial_out_write       (serial_out_write),
        .device_type            (device_type),
        .frame_count            (frame_count)
    );

    // Scoreboard: every written byte must be the oldest expected one.
    always @(negedge clk) begin
        if (reset_n && serial_out_write) begin
            logic [7:0] exp;
            write_cnt = write_cnt + 1;
            asserts = asserts + 1;
            if (exp_q.size() == 0) begin
                fails = fails + 1;
                $display("FAIL unexpected_write got=%02h expected=none", serial_out_data);
            end else begin
                exp = exp_q.pop_front();
                if (serial_out_data !== exp) begin
                    fails = fails + 1;
                    $display("FAIL byte got=%02h expected=%02h", serial_out_data, exp);
                end
            end
        end
    end

    task automatic push_frame(input logic [7:0] f0, input logic [7:0] f1, input logic [7:0] f2);
        exp_q.push_back(f0);
        exp_q.push_back(f1);
        exp_q.push_back(f2);
        exp_frames = exp_frames + 1;
    endtask

    task automatic drain(input int budget, output int left);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        left = exp_q.size();
        if (left != 0) exp_q.delete();
    endtask

    task automatic mouse_move(input logic [8:0] dx);
        @(negedge clk);
        mister_mouse[4]     = dx[8];
        mister_mouse[15:8]  = dx[7:0];
        mister_mouse[5]     = 1'b0;
        mister_mouse[23:16] = 8'h00;
        mister_mouse[24]    = ~mister_mouse[24];
        @(negedge clk);
    endtask

    task automatic test_reset();
        int left, w0;
        repeat (3) @(negedge clk);
        asserts += 4;
        if (serial_out_write !== 1'b0) begin fails++; $display("FAIL reset_write got=%0b expected=0", serial_out_write); end
        if (serial_out_data !== 8'h00) begin fails++; $display("FAIL reset_data got=%02h expected=00", serial_out_data); end
        if (device_type !== 1'b0) begin fails++; $display("FAIL reset_devtype got=%0b expected=0", device_type); end
        if (frame_count !== 16'd0) begin fails++; $display("FAIL reset_frames got=%0d expected=0", frame_count); end
        reset_n = 1'b1;
        @(negedge clk);
        rts = 1'b1;
        repeat (2) @(negedge clk);
        rts = 1'b0;
        exp_q.push_back(8'hCA);
        drain(3 * TICKS, left);
        asserts++;
        if (left !== 0) begin fails++; $display("FAIL reset_id_timeout pending=%0d expected=0", left); end
        w0 = write_cnt;
        repeat (6 * TICKS) @(negedge clk);
        asserts++;
        if (write_cnt !== w0) begin fails++; $display("FAIL reset_quiet writes=%0d expected=%0d", write_cnt, w0); end
    endtask

    task automatic test_digital_right();
        int left, w0;
        mister_joystick = 16'h0001;
        for (int i = 0; i < 5; i++) push_frame(8'hC0, 8'h82, 8'h80);
        push_frame(8'hC0, 8'h88, 8'h80);
        drain(22 * TICKS, left);
        asserts++;
        if (left !== 0) begin fails++; $display("FAIL right_timeout pending=%0d expected=0", left); end
        mister_joystick = 16'h0000;
        push_frame(8'hC0, 8'h80, 8'h80);
        drain(6 * TICKS, left);
        asserts++;
        if (left !== 0) begin fails++; $display("FAIL right_release_timeout pending=%0d expected=0", left); end
        w0 = write_cnt;
        repeat (6 * TICKS) @(negedge clk);
        asserts += 2;
        if (write_cnt !== w0) begin fails++; $display("FAIL right_quiet writes=%0d expected=%0d", write_cnt, w0); end
        if (frame_count !== 16'(exp_frames)) begin fails++; $display("FAIL right_frames got=%0d expected=%0d", frame_count, exp_frames); end
    endtask

    task automatic test_digital_left_button();
        int left, w0;
        mister_joystick = 16'h0012;
        push_frame(8'hD3, 8'hBE, 8'h80);
        drain(6 * TICKS, left);
        asserts++;
        if (left !== 0) begin fails++; $display("FAIL left_timeout pending=%0d expected=0", left); end
        mister_joystick = 16'h0000;
        push_frame(8'hC0, 8'h80, 8'h80);
        drain(6 * TICKS, left);
        w0 = write_cnt;
        repeat (6 * TICKS) @(negedge clk);
        asserts += 2;
        if (left !== 0) begin fails++; $display("FAIL left_release_timeout pending=%0d expected=0", left); end
        if (write_cnt !== w0) begin fails++; $display("FAIL left_quiet writes=%0d expected=%0d", write_cnt, w0); end
    endtask

    task automatic test_analog();
        int left, w0;
        mister_joystick_analog = 16'h0032;
        push_frame(8'hC0, 8'h86, 8'h80);
        drain(6 * TICKS, left);
        asserts++;
        if (left !== 0) begin fails++; $display("FAIL analog_timeout pending=%0d expected=0", left); end
        mister_joystick_analog = 16'h000A;
        push_frame(8'hC0, 8'h80, 8'h80);
        drain(6 * TICKS, left);
        w0 = write_cnt;
        repeat (6 * TICKS) @(negedge clk);
        asserts += 3;
        if (left !== 0) begin fails++; $display("FAIL analog_zero_timeout pending=%0d expected=0", left); end
        if (write_cnt !== w0) begin fails++; $display("FAIL analog_deadzone_quiet writes=%0d expected=%0d", write_cnt, w0); end
        if (frame_count !== 16'(exp_frames)) begin fails++; $display("FAIL analog_frames got=%0d expected=%0d", frame_count, exp_frames); end
        mister_joystick_analog = 16'h0000;
    endtask

    task automatic test_ready_stall();
        int left, w0;
        mister_joystick = 16'h0001;
        exp_q.push_back(8'hC0);
        drain(4 * TICKS, left);
        serial_ready = 1'b0;
        exp_q.push_back(8'h82);
        exp_q.push_back(8'h80);
        exp_frames++;
        w0 = write_cnt;
        repeat (3 * TICKS) @(negedge clk);
        asserts += 2;
        if (left !== 0) begin fails++; $display("FAIL stall_byte0_timeout pending=%0d expected=0", left); end
        if (write_cnt !== w0) begin fails++; $display("FAIL stall_no_write writes=%0d expected=%0d", write_cnt, w0); end
        serial_ready = 1'b1;
        repeat (3) @(negedge clk);
        asserts++;
        if (write_cnt !== w0 + 1) begin fails++; $display("FAIL stall_resume writes=%0d expected=%0d", write_cnt, w0 + 1); end
        drain(3 * TICKS, left);
        mister_joystick = 16'h0000;
        push_frame(8'hC0, 8'h80, 8'h80);
        drain(6 * TICKS, left);
        repeat (2 * TICKS) @(negedge clk);
        asserts += 2;
        if (left !== 0) begin fails++; $display("FAIL stall_release_timeout pending=%0d expected=0", left); end
        if (frame_count !== 16'(exp_frames)) begin fails++; $display("FAIL stall_frames got=%0d expected=%0d", frame_count, exp_frames); end
    endtask

    task automatic test_rts_abort();
        int left, w0;
        mister_joystick = 16'h0001;
        exp_q.push_back(8'hC0);
        drain(4 * TICKS, left);
        asserts++;
        if (left !== 0) begin fails++; $display("FAIL rts_byte0_timeout pending=%0d expected=0", left); end
        rts = 1'b1;
        mister_joystick = 16'h0000;
        repeat (3) @(negedge clk);
        rts = 1'b0;
        exp_q.push_back(8'hCA);
        push_frame(8'hC0, 8'h80, 8'h80);
        drain(8 * TICKS, left);
        w0 = write_cnt;
        repeat (6 * TICKS) @(negedge clk);
        asserts += 3;
        if (left !== 0) begin fails++; $display("FAIL rts_id_timeout pending=%0d expected=0", left); end
        if (write_cnt !== w0) begin fails++; $display("FAIL rts_quiet writes=%0d expected=%0d", write_cnt, w0); end
        if (frame_count !== 16'(exp_frames)) begin fails++; $display("FAIL rts_frames got=%0d expected=%0d", frame_count, exp_frames); end
    endtask

    task automatic test_mode_force();
        int w0;
        mode_force = 2'd1;
        w0 = write_cnt;
        mouse_move(9'd20);
        mouse_move(9'd20);
        repeat (5 * TICKS) @(negedge clk);
        asserts += 2;
        if (write_cnt !== w0) begin fails++; $display("FAIL force_quiet writes=%0d expected=%0d", write_cnt, w0); end
        if (device_type !== 1'b0) begin fails++; $display("FAIL force_devtype got=%0b expected=0", device_type); end
        mode_force = 2'd0;
        repeat (3 * TICKS) @(negedge clk);
        asserts++;
        if (write_cnt !== w0) begin fails++; $display("FAIL force_release_quiet writes=%0d expected=%0d", write_cnt, w0); end
    endtask

    task automatic test_mouse();
        int left, w0;
        mouse_move(9'd5);
        exp_q.push_back(8'hCD);
        drain(4 * TICKS, left);
        asserts += 2;
        if (left !== 0) begin fails++; $display("FAIL mouse_id_timeout pending=%0d expected=0", left); end
        if (device_type !== 1'b1) begin fails++; $display("FAIL mouse_devtype got=%0b expected=1", device_type); end
        mouse_move(9'd5);
        mouse_move(9'd5);
        push_frame(8'hC0, 8'h8A, 8'h80);
        drain(6 * TICKS, left);
        asserts++;
        if (left !== 0) begin fails++; $display("FAIL mouse_sum_timeout pending=%0d expected=0", left); end
        push_frame(8'hC0, 8'h80, 8'h80);
        drain(6 * TICKS, left);
        mouse_move(9'd100);
        mouse_move(9'd100);
        mouse_move(9'd100);
        push_frame(8'hC1, 8'hBF, 8'h80);
        push_frame(8'hC0, 8'h80, 8'h80);
        drain(10 * TICKS, left);
        w0 = write_cnt;
        repeat (6 * TICKS) @(negedge clk);
        asserts += 4;
        if (left !== 0) begin fails++; $display("FAIL mouse_sat_timeout pending=%0d expected=0", left); end
        if (write_cnt !== w0) begin fails++; $display("FAIL mouse_quiet writes=%0d expected=%0d", write_cnt, w0); end
        if (device_type !== 1'b1) begin fails++; $display("FAIL mouse_devtype_hold got=%0b expected=1", device_type); end
        if (frame_count !== 16'(exp_frames)) begin fails++; $display("FAIL mouse_frames got=%0d expected=%0d", frame_count, exp_frames); end
    endtask

    initial begin
        test_reset();
        test_digital_right();
        test_digital_left_button();
        test_analog();
        test_ready_stall();
        test_rts_abort();
        test_mode_force();
        test_mouse();
        $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
        $finish;
    end

endmodule
